ising_host_seq: RTL and testbench

- Hardware initiator for the `ising_axi` register interface. It replaces the bench-driven programming sequence with on-chip logic.
- It accepts weight-write commands from a host stream and programs the counter cutoff and maximum.
- It then starts the core, runs it for a programmed number of clocks, stops it, and reads back all N phase registers.
- The phases are emitted on a valid/ready output stream. The block sits between a host/CPU-side controller and `ising_axi`.

---
 rtl/ising_host_seq.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_ising_host_seq.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ising_host_seq.sv
// ising_host_seq
// On-chip initiator for the ising_axi register interface. It programs
// coupling weights from a host command stream. On go it writes the counter
// cutoff and maximum, runs the core for a programmed number of clocks, and
// stops it. It then reads back every phase register and streams the phases
// out on a valid/ready interface.
//
// Ports
//   clk, axi_rstn        : core clock, asynchronous active-low reset
//   cmd_*                : weight command stream (i, j, weight code, mirror)
//   go                   : start a run (in IDLE) or restart a running core
//   cutoff/ctr_max       : counter programming values
//   run_cycles           : clocks spent with START=1
//   busy/done/rd_err     : status (done is a pulse, rd_err is sticky)
//   ph_*                 : phase output stream (index + 32-bit value)
//   wready/wr_addr/wdata : single-cycle register write strobe to the core
//   arvalid_q/araddr_q   : single-cycle read request
//   rready/rvalid/rresp/rdata : read-data channel
//
// All outputs are registers, decoded from the next state so that they line
// up with the state they belong to (go -> first write is one clock).
module ising_host_seq #(
    parameter int          N                = 8,
    parameter int          NUM_WEIGHTS      = 3,
    parameter int          RUN_W            = 24,
    parameter logic [31:0] WEIGHT_ADDR_BASE = 32'h0001_0000,
    parameter logic [31:0] CTR_CUTOFF_ADDR  = 32'h0000_0008,
    parameter logic [31:0] CTR_MAX_ADDR     = 32'h0000_000C,
    parameter logic [31:0] START_ADDR       = 32'h0000_0000,
    parameter logic [31:0] PHASE_ADDR_BASE  = 32'h0000_1000,
    localparam int         IW               = (N > 1) ? $clog2(N) : 1
) (
    input  logic                   clk,
    input  logic                   axi_rstn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [IW-1:0]          cmd_i,
    input  logic [IW-1:0]          cmd_j,
    input  logic [NUM_WEIGHTS-1:0] cmd_w,
    input  logic                   cmd_sym,
    input  logic                   go,
    input  logic [31:0]            cutoff,
    input  logic [31:0]            ctr_max,
    input  logic [RUN_W-1:0]       run_cycles,
    output logic                   busy,
    output logic                   done,
    output logic                   rd_err,
    output logic                   ph_valid,
    input  logic                   ph_ready,
    output logic [IW-1:0]          ph_idx,
    output logic [31:0]            ph_data,
    output logic                   wready,
    output logic [31:0]            wr_addr,
    output logic [31:0]            wdata,
    output logic                   arvalid_q,
    output logic [31:0]            araddr_q,
    output logic                   rready,
    input  logic                   rvalid,
    input  logic [1:0]             rresp,
    input  logic [31:0]            rdata
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_W1    = 4'd1,
        S_W2    = 4'd2,
        S_CUT   = 4'd3,
        S_MAX   = 4'd4,
        S_STRT  = 4'd5,
        S_RUN   = 4'd6,
        S_RSTOP = 4'd7,
        S_STOP  = 4'd8,
        S_RDQ   = 4'd9,
        S_RDW   = 4'd10,
        S_OUT   = 4'd11,
        S_DONE  = 4'd12
    } state_t;

    state_t                 state_r, state_next_s;
    logic [IW-1:0]          k_r, k_next_s;
    logic [RUN_W-1:0]       cnt_r;
    logic [RUN_W-1:0]       run_lat_r;
    logic [31:0]            ctr_max_r;
    logic [IW-1:0]          ci_r, cj_r;
    logic [NUM_WEIGHTS-1:0] cw_r;
    logic                   csym_r;
    logic                   wr_s;
    logic [31:0]            wr_addr_s, wdata_s;
    logic                   take_cmd_s, take_go_s, restart_s;
    logic                   rd_hs_s;

    // (i,j) weight location: row index in the word offset, column in bit 13 up
    function automatic logic [31:0] weight_addr(input logic [IW-1:0] i,
                                                input logic [IW-1:0] j);
        weight_addr = WEIGHT_ADDR_BASE + (32'(i) << 2) + (32'(j) << 13);
    endfunction

    assign rd_hs_s = (state_r == S_RDW) && rvalid && rready;

    // Next-state decode; also selects the write (if any) issued on entry to the next state
    always_comb begin
        state_next_s = state_r;
        k_next_s     = k_r;
        wr_s         = 1'b0;
        wr_addr_s    = wr_addr;
        wdata_s      = wdata;
        take_cmd_s   = 1'b0;
        take_go_s    = 1'b0;
        restart_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                // A pending command takes priority over go
                if (cmd_valid && cmd_ready) begin
                    take_cmd_s   = 1'b1;
                    state_next_s = S_W1;
                    wr_s         = 1'b1;
                    wr_addr_s    = weight_addr(cmd_i, cmd_j);
                    wdata_s      = 32'(cmd_w);
                end else if (go && cmd_ready) begin
                    take_go_s    = 1'b1;
                    state_next_s = S_CUT;
                    wr_s         = 1'b1;
                    wr_addr_s    = CTR_CUTOFF_ADDR;
                    wdata_s      = cutoff;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_W1: begin
                if (csym_r && (ci_r != cj_r)) begin
                    state_next_s = S_W2;
                    wr_s         = 1'b1;
                    wr_addr_s    = weight_addr(cj_r, ci_r);
                    wdata_s      = 32'(cw_r);
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_W2:  state_next_s = S_IDLE;
            S_CUT: begin
                state_next_s = S_MAX;
                wr_s         = 1'b1;
                wr_addr_s    = CTR_MAX_ADDR;
                wdata_s      = ctr_max_r;
            end
            S_MAX: begin
                state_next_s = S_STRT;
                wr_s         = 1'b1;
                wr_addr_s    = START_ADDR;
                wdata_s      = 32'd1;
            end
            S_STRT: state_next_s = S_RUN;
            S_RUN: begin
                if (go) begin
                    restart_s    = 1'b1;
                    state_next_s = S_RSTOP;
                    wr_s         = 1'b1;
                    wr_addr_s    = START_ADDR;
                    wdata_s      = 32'd0;
                end else if (cnt_r <= RUN_W'(1)) begin
                    state_next_s = S_STOP;
                    wr_s         = 1'b1;
                    wr_addr_s    = START_ADDR;
                    wdata_s      = 32'd0;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_RSTOP: begin
                state_next_s = S_STRT;
                wr_s         = 1'b1;
                wr_addr_s    = START_ADDR;
                wdata_s      = 32'd1;
            end
            S_STOP: begin
                state_next_s = S_RDQ;
                k_next_s     = '0;
            end
            S_RDQ: state_next_s = S_RDW;
            S_RDW: begin
                if (rd_hs_s) begin
                    state_next_s = S_OUT;
                end else begin
                    state_next_s = S_RDW;
                end
            end
            S_OUT: begin
                if (ph_ready) begin
                    if (k_r == IW'(N - 1)) begin
                        state_next_s = S_DONE;
                    end else begin
                        state_next_s = S_RDQ;
                        k_next_s     = k_r + 1'b1;
                    end
                end else begin
                    state_next_s = S_OUT;
                end
            end
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State, index and registered interface outputs
    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state_r   <= S_IDLE;
            k_r       <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_err    <= 1'b0;
            ph_valid  <= 1'b0;
            ph_idx    <= '0;
            ph_data   <= 32'd0;
            wready    <= 1'b0;
            wr_addr   <= 32'd0;
            wdata     <= 32'd0;
            arvalid_q <= 1'b0;
            araddr_q  <= 32'd0;
            rready    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            k_r       <= k_next_s;
            cmd_ready <= (state_next_s == S_IDLE);
            busy      <= (state_next_s != S_IDLE);
            done      <= (state_next_s == S_DONE);
            ph_valid  <= (state_next_s == S_OUT);
            rready    <= (state_next_s == S_RDW);
            arvalid_q <= (state_next_s == S_RDQ);
            wready    <= wr_s;
            wr_addr   <= wr_addr_s;
            wdata     <= wdata_s;
            if (state_next_s == S_RDQ) begin
                araddr_q <= PHASE_ADDR_BASE + (32'(k_next_s) << 2);
            end
            if (rd_hs_s) begin
                ph_data <= rdata;
                ph_idx  <= k_r;
            end
            if (take_go_s) begin
                rd_err <= 1'b0;
            end else if (rd_hs_s && (rresp != 2'b00)) begin
                rd_err <= 1'b1;
            end
        end
    end

    // Latched command fields and run parameters
    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            ci_r      <= '0;
            cj_r      <= '0;
            cw_r      <= '0;
            csym_r    <= 1'b0;
            ctr_max_r <= 32'd0;
            run_lat_r <= '0;
        end else begin
            if (take_cmd_s) begin
                ci_r   <= cmd_i;
                cj_r   <= cmd_j;
                cw_r   <= cmd_w;
                csym_r <= cmd_sym;
            end
            if (take_go_s) begin
                ctr_max_r <= ctr_max;
                run_lat_r <= run_cycles;
            end else if (restart_s) begin
                run_lat_r <= run_cycles;
            end
        end
    end

    // Run counter: loaded while START=1 is written, a zero count runs one clock
    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            cnt_r <= '0;
        end else if (state_r == S_STRT) begin
            cnt_r <= (run_lat_r == '0) ? RUN_W'(1) : run_lat_r;
        end else if (state_r == S_RUN) begin
            cnt_r <= cnt_r - RUN_W'(1);
        end
    end

endmodule

// File: tb/tb_ising_host_seq.sv
// Bench for ising_host_seq: models the ising_axi read slave and a phase
// consumer, keeps scoreboards of expected core writes and expected phases.
module tb_ising_host_seq;

    localparam int          N                = 8;
    localparam int          IW               = 3;
    localparam int          NUM_WEIGHTS      = 3;
    localparam int          RUN_W            = 24;
    localparam logic [31:0] WEIGHT_ADDR_BASE = 32'h0001_0000;
    localparam logic [31:0] CTR_CUTOFF_ADDR  = 32'h0000_0008;
    localparam logic [31:0] CTR_MAX_ADDR     = 32'h0000_000C;
    localparam logic [31:0] START_ADDR       = 32'h0000_0000;
    localparam logic [31:0] PHASE_ADDR_BASE  = 32'h0000_1000;

    logic                   clk;
    logic                   axi_rstn;
    logic                   cmd_valid, cmd_ready;
    logic [IW-1:0]          cmd_i, cmd_j;
    logic [NUM_WEIGHTS-1:0] cmd_w;
    logic                   cmd_sym, go;
    logic [31:0]            cutoff, ctr_max;
    logic [RUN_W-1:0]       run_cycles;
    logic                   busy, done, rd_err;
    logic                   ph_valid, ph_ready;
    logic [IW-1:0]          ph_idx;
    logic [31:0]            ph_data;
    logic                   wready;
    logic [31:0]            wr_addr, wdata;
    logic                   arvalid_q;
    logic [31:0]            araddr_q;
    logic                   rready, rvalid;
    logic [1:0]             rresp;
    logic [31:0]            rdata;

    ising_host_seq #(
        .N(N), .NUM_WEIGHTS(NUM_WEIGHTS), .RUN_W(RUN_W),
        .WEIGHT_ADDR_BASE(WEIGHT_ADDR_BASE), .CTR_CUTOFF_ADDR(CTR_CUTOFF_ADDR),
        .CTR_MAX_ADDR(CTR_MAX_ADDR), .START_ADDR(START_ADDR),
        .PHASE_ADDR_BASE(PHASE_ADDR_BASE)
    ) dut (
        .clk(clk), .axi_rstn(axi_rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_i(cmd_i), .cmd_j(cmd_j),
        .cmd_w(cmd_w), .cmd_sym(cmd_sym), .go(go), .cutoff(cutoff), .ctr_max(ctr_max),
        .run_cycles(run_cycles), .busy(busy), .done(done), .rd_err(rd_err),
        .ph_valid(ph_valid), .ph_ready(ph_ready), .ph_idx(ph_idx), .ph_data(ph_data),
        .wready(wready), .wr_addr(wr_addr), .wdata(wdata),
        .arvalid_q(arvalid_q), .araddr_q(araddr_q),
        .rready(rready), .rvalid(rvalid), .rresp(rresp), .rdata(rdata)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          st_cyc[$];
    logic [63:0] wq[$];
    logic [39:0] pq[$];
    logic [31:0] phase_tbl[N];
    int          err_idx = 99;
    bit          stall_en = 1'b0;
    int          edges[5][3] = '{'{0, 1, 4}, '{0, 4, 4}, '{1, 2, 4}, '{2, 3, 4}, '{3, 7, 4}};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] w_addr(input int i, input int j);
        return WEIGHT_ADDR_BASE + 32'(i * 4) + 32'(j * 8192);
    endfunction

    task automatic push_w(input logic [31:0] a, input logic [31:0] d);
        wq.push_back({a, d});
    endtask

    // Core-side write monitor: every strobe must match the next expected write
    always @(negedge clk) begin
        logic [63:0] e;
        if (wready) begin
            check_val("wr_expected", 64'(wq.size() != 0), 64'd1);
            if (wq.size() != 0) begin
                e = wq.pop_front();
                check_val("wr_addr", wr_addr, e[63:32]);
                check_val("wr_data", wdata, e[31:0]);
            end
            if (wr_addr == START_ADDR) st_cyc.push_back(cyc);
        end
        if (arvalid_q) begin
            check_val("rd_with_wr", wready, 1'b0);
            check_val("rd_while_ph_pending", ph_valid, 1'b0);
        end
        if (done) done_cnt++;
    end

    // Read slave: answers each request two cycles later from phase_tbl
    initial begin
        logic [31:0] rd_idx;
        int          rd_wait;
        bit          hs_pend;
        rvalid = 1'b0; rdata = 32'd0; rresp = 2'd0;
        rd_wait = 0; hs_pend = 1'b0; rd_idx = 32'd0;
        forever begin
            @(negedge clk);
            if (!axi_rstn) begin
                rvalid = 1'b0; rd_wait = 0; hs_pend = 1'b0;
            end else begin
                if (hs_pend) begin rvalid = 1'b0; hs_pend = 1'b0; end
                if (arvalid_q) begin
                    rd_idx  = (araddr_q - PHASE_ADDR_BASE) >> 2;
                    rd_wait = 2;
                end else if (rd_wait > 0) begin
                    rd_wait--;
                    if (rd_wait == 0) begin
                        rvalid = 1'b1;
                        rdata  = (rd_idx < 32'(N)) ? phase_tbl[rd_idx[2:0]] : 32'hBAD0_0000;
                        rresp  = (int'(rd_idx) == err_idx) ? 2'd2 : 2'd0;
                    end
                end
                if (rvalid && rready) hs_pend = 1'b1;
            end
        end
    end

    // Phase consumer: optional 5-cycle stall on index 2, then scoreboard compare
    initial begin
        logic [39:0] e;
        logic [31:0] held;
        ph_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (ph_valid) begin
                if (stall_en && ph_idx == 3'd2) begin
                    stall_en = 1'b0;
                    held     = ph_data;
                    ph_ready = 1'b0;
                    for (int s = 0; s < 5; s++) begin
                        @(negedge clk);
                        check_val("stall_valid", ph_valid, 1'b1);
                        check_val("stall_idx", ph_idx, 3'd2);
                        check_val("stall_data", ph_data, held);
                    end
                    ph_ready = 1'b1;
                end
                check_val("ph_expected", 64'(pq.size() != 0), 64'd1);
                if (pq.size() != 0) begin
                    e = pq.pop_front();
                    check_val("ph_idx", ph_idx, e[39:32]);
                    check_val("ph_data", ph_data, e[31:0]);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ctl"}, {cmd_ready, busy, done, rd_err, ph_valid, wready, arvalid_q, rready}, 8'd0);
        check_val({tag, "_wr_addr"}, wr_addr, 32'd0);
        check_val({tag, "_wdata"}, wdata, 32'd0);
        check_val({tag, "_araddr"}, araddr_q, 32'd0);
        check_val({tag, "_ph"}, {ph_idx, ph_data}, 35'd0);
    endtask

    task automatic send_cmd(input int i, input int j, input int w, input bit sym, input bit with_go);
        int n;
        push_w(w_addr(i, j), 32'(w));
        if (sym && i != j) push_w(w_addr(j, i), 32'(w));
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        cmd_i = IW'(i); cmd_j = IW'(j); cmd_w = NUM_WEIGHTS'(w); cmd_sym = sym;
        cmd_valid = 1'b1; go = with_go;
        @(negedge clk);
        cmd_valid = 1'b0; go = 1'b0;
        check_val("cmd_ready_low", cmd_ready, 1'b0);
        n = 0;
        while (!cmd_ready && n < 10) begin @(negedge clk); n++; end
        check_val("cmd_busy_cycles", n, (sym && i != j) ? 2 : 1);
        check_val("cmd_writes_drained", wq.size(), 0);
    endtask

    task automatic arm_run(input logic [31:0] cut, input logic [31:0] mx, input bit restart);
        cutoff = cut; ctr_max = mx;
        push_w(CTR_CUTOFF_ADDR, cut);
        push_w(CTR_MAX_ADDR, mx);
        push_w(START_ADDR, 32'd1);
        if (restart) begin
            push_w(START_ADDR, 32'd0);
            push_w(START_ADDR, 32'd1);
        end
        push_w(START_ADDR, 32'd0);
        for (int k = 0; k < N; k++) pq.push_back({8'(k), phase_tbl[k]});
    endtask

    task automatic pulse_go(output int g);
        go = 1'b1; g = cyc;
        @(negedge clk);
        go = 1'b0;
        check_val("go_to_wready", wready, 1'b1);
        check_val("go_busy", busy, 1'b1);
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n;
        n = 0;
        while (!done && n < limit) begin @(negedge clk); n++; end
        check_val({tag, "_done_seen"}, done, 1'b1);
    endtask

    initial begin
        int base, g, d0, n;
        axi_rstn = 1'b0; cmd_valid = 1'b0; cmd_i = '0; cmd_j = '0; cmd_w = '0;
        cmd_sym = 1'b0; go = 1'b0; cutoff = 32'd0; ctr_max = 32'd0; run_cycles = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        axi_rstn = 1'b1;
        @(negedge clk);
        check_val("post_reset_cmd_ready", cmd_ready, 1'b1);

        // Weight commands: mirrored pair, diagonal, then a small graph
        send_cmd(0, 1, 1, 1'b1, 1'b0);
        send_cmd(3, 3, 4, 1'b1, 1'b0);
        for (int e = 0; e < 5; e++) send_cmd(edges[e][0], edges[e][1], edges[e][2], 1'b1, 1'b0);
        send_cmd(5, 6, 2, 1'b0, 1'b0);

        // Run 1: 600 clocks, stall on index 2
        phase_tbl = '{32'd6, 32'd2, 32'd5, 32'd4, 32'd1, 32'd3, 32'd7, 32'd4};
        err_idx = 99; stall_en = 1'b1; run_cycles = RUN_W'(600);
        arm_run(32'd4, 32'd8, 1'b0);
        base = st_cyc.size(); d0 = done_cnt;
        pulse_go(g);
        wait_done("run1", 3000);
        check_val("run1_rd_err", rd_err, 1'b0);
        repeat (2) @(negedge clk);
        check_val("run1_done_once", done_cnt - d0, 1);
        check_val("run1_idle", busy, 1'b0);
        check_val("run1_stall_used", stall_en, 1'b0);
        check_val("run1_phases_left", pq.size(), 0);
        if (st_cyc.size() == base + 2) check_val("run1_start_to_stop", st_cyc[base+1] - st_cyc[base], 601);
        else check_val("run1_start_writes", st_cyc.size() - base, 2);

        // Run 2: restart 100 clocks into RUN with a new run length, read error on idx 5
        for (int k = 0; k < N; k++) phase_tbl[k] = $urandom;
        err_idx = 5; run_cycles = RUN_W'(300);
        arm_run(32'd9, 32'd17, 1'b1);
        base = st_cyc.size(); d0 = done_cnt;
        pulse_go(g);
        n = 0;
        while (st_cyc.size() < base + 1 && n < 50) begin @(negedge clk); n++; end
        repeat (100) @(negedge clk);
        run_cycles = RUN_W'(200);
        go = 1'b1; g = cyc;
        @(negedge clk);
        go = 1'b0;
        wait_done("run2", 2000);
        check_val("run2_rd_err_at_done", rd_err, 1'b1);
        repeat (3) @(negedge clk);
        check_val("run2_rd_err_sticky", rd_err, 1'b1);
        check_val("run2_done_once", done_cnt - d0, 1);
        if (st_cyc.size() == base + 4) begin
            check_val("restart_go_to_stop", st_cyc[base+1] - g, 1);
            check_val("restart_stop_to_start", st_cyc[base+2] - st_cyc[base+1], 1);
            check_val("restart_start_to_stop", st_cyc[base+3] - st_cyc[base+2], 201);
        end else begin
            check_val("run2_start_writes", st_cyc.size() - base, 4);
        end

        // Run 3: zero run length behaves as one clock; go clears rd_err
        err_idx = 99; run_cycles = RUN_W'(0);
        arm_run(32'd1, 32'd2, 1'b0);
        base = st_cyc.size();
        pulse_go(g);
        check_val("go_clears_rd_err", rd_err, 1'b0);
        wait_done("run3", 500);
        if (st_cyc.size() == base + 2) check_val("run3_start_to_stop", st_cyc[base+1] - st_cyc[base], 2);
        else check_val("run3_start_writes", st_cyc.size() - base, 2);
        repeat (2) @(negedge clk);

        // go together with a command: only the command is served
        send_cmd(2, 5, 3, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check_val("cmd_beats_go", busy, 1'b0);

        // Reset while waiting for read data
        run_cycles = RUN_W'(3);
        arm_run(32'd5, 32'd6, 1'b0);
        pulse_go(g);
        n = 0;
        while (!rready && n < 200) begin @(negedge clk); n++; end
        check_val("rdw_reached", rready, 1'b1);
        axi_rstn = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        pq.delete();
        check_val("mid_reset_writes_done", wq.size(), 0);
        repeat (3) @(negedge clk);
        axi_rstn = 1'b1;
        repeat (20) @(negedge clk);
        check_val("after_reset_idle", {busy, cmd_ready, wready, arvalid_q}, 4'b0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached (compared %0d)", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
